// File: rtl/pc_seq_pkg.sv
// Shared decode constants and helpers for the PC sequencer.
// Maps IR fields to an instruction kind and its execute-cycle count.
package pc_seq_pkg;

  localparam logic [1:0] IR_R   = 2'b00;
  localparam logic [1:0] IR_I   = 2'b01;
  localparam logic [1:0] IR_J   = 2'b10;
  localparam logic [1:0] IR_ILL = 2'b11;

  localparam logic [3:0] OP_ANDI = 4'b0010;
  localparam logic [3:0] OP_ADDI = 4'b0011;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_BNE  = 4'b0111;
  localparam logic [3:0] OP_FOR  = 4'b1000;

  localparam logic [2:0] FN_JMP  = 3'b000;
  localparam logic [2:0] FN_CALL = 3'b001;
  localparam logic [2:0] FN_RET  = 3'b010;

  typedef enum logic [2:0] {
    K_SEQ,
    K_BEQ,
    K_BNE,
    K_FOR,
    K_JMP,
    K_CALL,
    K_RET,
    K_ILL
  } kind_e;

  function automatic kind_e decode(
    input logic [1:0] ir_type,
    input logic [3:0] opcode,
    input logic [2:0] func
  );
    kind_e k;
    k = K_ILL;
    unique case (ir_type)
      IR_R: k = K_SEQ;
      IR_I: begin
        unique case (opcode)
          OP_ANDI, OP_ADDI,
          OP_LW, OP_SW: k = K_SEQ;
          OP_BEQ:       k = K_BEQ;
          OP_BNE:       k = K_BNE;
          OP_FOR:       k = K_FOR;
          default:      k = K_ILL;
        endcase
      end
      IR_J: begin
        unique case (func)
          FN_JMP:  k = K_JMP;
          FN_CALL: k = K_CALL;
          FN_RET:  k = K_RET;
          default: k = K_ILL;
        endcase
      end
      default: k = K_ILL;
    endcase
    return k;
  endfunction

  function automatic int unsigned cycles_for(
    input logic [1:0]  ir_type,
    input logic [3:0]  opcode,
    input logic [2:0]  func,
    input int unsigned cyc_alu,
    input int unsigned cyc_lw,
    input int unsigned cyc_br
  );
    kind_e k;
    int unsigned n;
    k = decode(ir_type, opcode, func);
    n = cyc_alu;
    unique case (1'b1)
      (ir_type == IR_I && opcode == OP_LW): n = cyc_lw;
      (k inside {K_BEQ, K_BNE, K_FOR,
                 K_JMP, K_CALL, K_RET}): n = cyc_br;
      default: n = cyc_alu;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode-field inputs and sequencing outputs of the PC sequencer.
// master drives decode fields; slave is the sequencer itself.
interface pc_sequencer_if #(
  parameter int PC_WIDTH = 16,
  parameter int CNT_W    = 3
);
  logic [1:0]          ir_type;
  logic [3:0]          opcode;
  logic [2:0]          func;
  logic                zero;
  logic                iterations_zero;
  logic                stall;
  logic [PC_WIDTH-1:0] branch_target;
  logic [PC_WIDTH-1:0] jump_target;
  logic [PC_WIDTH-1:0] pc;
  logic                pc_write;
  logic [CNT_W-1:0]    cycle_idx;
  logic                illegal;
  logic                ras_overflow;
  logic                ras_underflow;

  modport master (
    output ir_type, opcode, func, zero,
    output iterations_zero, stall,
    output branch_target, jump_target,
    input  pc, pc_write, cycle_idx, illegal,
    input  ras_overflow, ras_underflow
  );

  modport slave (
    input  ir_type, opcode, func, zero,
    input  iterations_zero, stall,
    input  branch_target, jump_target,
    output pc, pc_write, cycle_idx, illegal,
    output ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack; a push when full drops the oldest entry.
// r_wp points at the next free slot, the top lives one slot below it.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data_in,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty,
  output logic             o_full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [CW-1:0]    r_cnt;
  logic [AW-1:0]    w_wp_inc;
  logic [AW-1:0]    w_wp_dec;

  always_comb begin
    w_wp_inc = (r_wp == AW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
    w_wp_dec = (r_wp == '0) ? AW'(DEPTH - 1) : r_wp - 1'b1;
    o_top    = r_mem[w_wp_dec];
    o_empty  = (r_cnt == '0);
    o_full   = (r_cnt == CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp  <= '0;
      r_cnt <= '0;
    end else if (i_push) begin
      r_mem[r_wp] <= i_data_in;
      r_wp        <= w_wp_inc;
      if (!o_full) r_cnt <= r_cnt + 1'b1;
    end else if (i_pop && !o_empty) begin
      r_wp  <= w_wp_dec;
      r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer: counts execute cycles, retires on the last,
// and loads the next PC (branch, FOR, JMP, CALL/RET through the RAS).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_WIDTH  = 16,
  parameter int RAS_DEPTH = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int CYC_ALU   = 4,
  parameter int CYC_LW    = 5,
  parameter int CYC_BR    = 3,
  parameter int CNT_W     = 3
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.slave  bus
);
  kind_e               w_kind;
  logic [CNT_W-1:0]    w_last_idx;
  logic                w_retire;
  logic                w_push;
  logic                w_pop;
  logic                w_empty;
  logic                w_full;
  logic [PC_WIDTH-1:0] w_pc1;
  logic [PC_WIDTH-1:0] w_next;
  logic [PC_WIDTH-1:0] w_top;

  logic [PC_WIDTH-1:0] r_pc;
  logic [CNT_W-1:0]    r_idx;
  logic                r_pc_write;
  logic                r_illegal;
  logic                r_ovf;
  logic                r_unf;

  always_comb begin
    w_kind     = decode(bus.ir_type, bus.opcode, bus.func);
    w_last_idx = CNT_W'(cycles_for(bus.ir_type, bus.opcode,
                   bus.func, CYC_ALU, CYC_LW, CYC_BR) - 1);
    w_retire   = !bus.stall && (r_idx == w_last_idx);
    w_pc1      = r_pc + PC_WIDTH'(1);
    w_push     = w_retire && (w_kind == K_CALL);
    w_pop      = w_retire && (w_kind == K_RET) && !w_empty;
  end

  always_comb begin
    w_next = w_pc1;
    unique case (w_kind)
      K_BEQ:  w_next = bus.zero ? bus.branch_target : w_pc1;
      K_BNE:  w_next = bus.zero ? w_pc1 : bus.branch_target;
      K_FOR:  w_next = bus.iterations_zero ? w_pc1
                                           : bus.branch_target;
      K_JMP,
      K_CALL: w_next = bus.jump_target;
      K_RET:  w_next = w_empty ? w_pc1 : w_top;
      default: w_next = w_pc1;
    endcase
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (PC_WIDTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_data_in (w_pc1),
    .o_top     (w_top),
    .o_empty   (w_empty),
    .o_full    (w_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_idx      <= '0;
      r_pc_write <= 1'b0;
      r_illegal  <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      r_pc_write <= 1'b0;
      r_illegal  <= 1'b0;
      if (w_retire) begin
        r_idx      <= '0;
        r_pc       <= w_next;
        r_pc_write <= 1'b1;
        r_illegal  <= (w_kind == K_ILL);
        if (w_push && w_full) r_ovf <= 1'b1;
        if (w_kind == K_RET && w_empty) r_unf <= 1'b1;
      end else if (!bus.stall) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign bus.pc            = r_pc;
  assign bus.pc_write      = r_pc_write;
  assign bus.cycle_idx     = r_idx;
  assign bus.illegal       = r_illegal;
  assign bus.ras_overflow  = r_ovf;
  assign bus.ras_underflow = r_unf;
endmodule
